// File: rtl/iter_barrel_shifter.sv
// Iterative ARM-style operand-2 shifter (LSL/LSR/ASR/ROR/RRX), one bit per clock,
// with a start/busy/done handshake toward the control unit.
module iter_barrel_shifter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        sh_type,
  input  logic [7:0]        shamt,
  input  logic              imm_mode,
  input  logic              c_in,
  output logic [DATA_W-1:0] dout,
  output logic              shiftCout,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | one bit step per cycle, counter counts down to terminal count 1
  // DONE  | dout/shiftCout valid for one cycle; a new start is accepted here
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d, op_sel;
  logic [DATA_W-1:0] data_q, data_d;
  logic              c_q, c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, n_steps;
  logic              accept;

  assign accept = start && (state_q != SHIFT);

  // Step count and operation from the live inputs; only used on the accept edge.
  always_comb begin
    n_steps = '0;
    op_sel  = OP_LSL;
    if (shamt == 8'd0) begin
      if (imm_mode) begin
        case (sh_type)
          2'b01:   begin op_sel = OP_LSR; n_steps = CNT_W'(32); end
          2'b10:   begin op_sel = OP_ASR; n_steps = CNT_W'(32); end
          2'b11:   begin op_sel = OP_RRX; n_steps = CNT_W'(1);  end
          default: begin op_sel = OP_LSL; n_steps = '0;         end
        endcase
      end
    end else begin
      case (sh_type)
        2'b00: begin
          op_sel  = OP_LSL;
          n_steps = (shamt > 8'd33) ? CNT_W'(33) : CNT_W'(shamt[5:0]);
        end
        2'b01: begin
          op_sel  = OP_LSR;
          n_steps = (shamt > 8'd33) ? CNT_W'(33) : CNT_W'(shamt[5:0]);
        end
        2'b10: begin
          op_sel  = OP_ASR;
          n_steps = (shamt > 8'd32) ? CNT_W'(32) : CNT_W'(shamt[5:0]);
        end
        default: begin
          op_sel  = OP_ROR;
          n_steps = (shamt[4:0] == 5'd0) ? CNT_W'(32) : CNT_W'(shamt[4:0]);
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      SHIFT: begin
        case (op_q)
          OP_LSL: begin
            c_d    = data_q[DATA_W-1];
            data_d = {data_q[DATA_W-2:0], 1'b0};
          end
          OP_LSR: begin
            c_d    = data_q[0];
            data_d = {1'b0, data_q[DATA_W-1:1]};
          end
          OP_ASR: begin
            c_d    = data_q[0];
            data_d = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
          end
          OP_ROR: begin
            c_d    = data_q[0];
            data_d = {data_q[0], data_q[DATA_W-1:1]};
          end
          default: begin
            // RRX: c_q still holds the latched CPSR C at this point
            c_d    = data_q[0];
            data_d = {c_q, data_q[DATA_W-1:1]};
          end
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      default: begin
        if (accept) begin
          op_d    = op_sel;
          data_d  = din;
          c_d     = c_in;
          cnt_d   = n_steps;
          state_d = (n_steps == '0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LSL;
      data_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout      = data_q;
  assign shiftCout = c_q;
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_iter_barrel_shifter.sv
// Directed vector bench for iter_barrel_shifter: table-driven shifts plus
// hand-written sequences for reset abort, ignored start and back-to-back issue.
module tb_iter_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] din;
  logic [1:0]  sh_type;
  logic [7:0]  shamt;
  logic        imm_mode;
  logic        c_in;
  logic [31:0] dout;
  logic        shiftCout;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  iter_barrel_shifter dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .sh_type(sh_type),
    .shamt(shamt), .imm_mode(imm_mode), .c_in(c_in), .dout(dout),
    .shiftCout(shiftCout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] din;
    logic [1:0]  typ;
    logic [7:0]  amt;
    logic        imm;
    logic        cin;
    logic [31:0] exp_dout;
    logic        exp_c;
    int          exp_n;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, count busy cycles, check result and single done pulse.
  task automatic do_op(input string name, input logic [31:0] d, input logic [1:0] t,
                       input logic [7:0] a, input logic im, input logic ci,
                       input logic [31:0] ed, input logic ec, input int en,
                       input bit poke);
    int cyc;
    @(negedge clk);
    din = d; sh_type = t; shamt = a; imm_mode = im; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din = ~d; shamt = 8'd3;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      start = poke && (cyc == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " busy_cycles"}, 32'(cyc), 32'(en));
    chk({name, " done"}, {31'b0, done}, 32'd1);
    chk({name, " dout"}, dout, ed);
    chk({name, " cout"}, {31'b0, shiftCout}, {31'b0, ec});
    @(negedge clk);
    chk({name, " done_clear"}, {31'b0, done}, 32'd0);
    chk({name, " dout_hold"}, dout, ed);
    if (poke) begin
      @(negedge clk);
      chk({name, " no_extra_done"}, {30'b0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{"lsl1",      32'h8000_0001, 2'b00, 8'd1,   1'b0, 1'b0, 32'h0000_0002, 1'b1, 1};
    vecs[1]  = '{"asr40",     32'h8000_0000, 2'b10, 8'd40,  1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 32};
    vecs[2]  = '{"rrx",       32'h0000_0003, 2'b11, 8'd0,   1'b1, 1'b1, 32'h8000_0001, 1'b1, 1};
    vecs[3]  = '{"lsr_reg0",  32'h1234_5678, 2'b01, 8'd0,   1'b0, 1'b0, 32'h1234_5678, 1'b0, 0};
    vecs[4]  = '{"lsr32",     32'h8000_0000, 2'b01, 8'd32,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 32};
    vecs[5]  = '{"lsl32",     32'h0000_0001, 2'b00, 8'd32,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 32};
    vecs[6]  = '{"lsl40",     32'hFFFF_FFFF, 2'b00, 8'd40,  1'b0, 1'b1, 32'h0000_0000, 1'b0, 33};
    vecs[7]  = '{"lsr_imm0",  32'h8000_0000, 2'b01, 8'd0,   1'b1, 1'b0, 32'h0000_0000, 1'b1, 32};
    vecs[8]  = '{"asr_imm0",  32'h7FFF_FFFF, 2'b10, 8'd0,   1'b1, 1'b1, 32'h0000_0000, 1'b0, 32};
    vecs[9]  = '{"lsl_imm0",  32'hA5A5_A5A5, 2'b00, 8'd0,   1'b1, 1'b1, 32'hA5A5_A5A5, 1'b1, 0};
    vecs[10] = '{"ror4",      32'h0000_00F1, 2'b11, 8'd4,   1'b0, 1'b0, 32'h1000_000F, 1'b0, 4};
    vecs[11] = '{"lsr4",      32'h0000_00F8, 2'b01, 8'd4,   1'b0, 1'b1, 32'h0000_000F, 1'b1, 4};
    vecs[12] = '{"asr8",      32'h8000_1234, 2'b10, 8'd8,   1'b0, 1'b0, 32'hFF80_0012, 1'b0, 8};
    vecs[13] = '{"lsr33",     32'hFFFF_FFFF, 2'b01, 8'd33,  1'b0, 1'b1, 32'h0000_0000, 1'b0, 33};
    vecs[14] = '{"ror255",    32'h0000_0001, 2'b11, 8'd255, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 31};
    vecs[15] = '{"ror_reg0",  32'hDEAD_BEEF, 2'b11, 8'd0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 0};

    rst = 1'b1; start = 1'b0; din = '0; sh_type = '0; shamt = '0; imm_mode = 1'b0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset dout", dout, 32'h0);
    chk("reset flags", {29'b0, shiftCout, busy, done}, 32'h0);

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].din, vecs[i].typ, vecs[i].amt, vecs[i].imm, vecs[i].cin,
            vecs[i].exp_dout, vecs[i].exp_c, vecs[i].exp_n, 1'b0);

    // ROR by 64 with a start pulse in the middle of the run that must be ignored
    do_op("ror64_poke", 32'h8000_0000, 2'b11, 8'd64, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 32, 1'b1);

    // Reset in the middle of an LSL by 20 aborts without a done pulse
    @(negedge clk);
    din = 32'h0000_0001; sh_type = 2'b00; shamt = 8'd20; imm_mode = 1'b0; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid flags", {29'b0, shiftCout, busy, done}, 32'h0);
    chk("rst_mid dout", dout, 32'h0);
    begin
      int seen = 0;
      repeat (25) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("rst_mid no_done", 32'(seen), 32'd0);
    end
    do_op("after_rst", 32'h0000_0001, 2'b00, 8'd20, 1'b0, 1'b0, 32'h0010_0000, 1'b0, 20, 1'b0);

    // Back-to-back: second start issued while first op sits in DONE
    @(negedge clk);
    din = 32'h4000_0000; sh_type = 2'b00; shamt = 8'd2; imm_mode = 1'b0; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int cyc = 0;
      while (!done && cyc < 10) begin
        cyc++;
        @(negedge clk);
      end
      chk("b2b first done", {31'b0, done}, 32'd1);
      chk("b2b first dout", dout, 32'h0000_0000);
      chk("b2b first cout", {31'b0, shiftCout}, 32'd1);
    end
    din = 32'h0000_0002; sh_type = 2'b01; shamt = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b second busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("b2b second done", {31'b0, done}, 32'd1);
    chk("b2b second dout", dout, 32'h0000_0001);
    chk("b2b second cout", {31'b0, shiftCout}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
